// File: rtl/conv_pkg.sv
// Shared FSM state encoding, default parameters and tap-index width helper for conv_engine.
// No logic; imported by conv_engine and conv_mac.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int KSIZE_DEF  = 3;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    FIN
  } conv_state_t;

  // A 1x1 kernel still needs a 1-bit index port
  function automatic int idx_w(input int ksize);
    return (ksize * ksize > 1) ? $clog2(ksize * ksize) : 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate over one kernel window, then shift and saturate; pixel data lands 1 cycle after rd_en.
// result is combinational from the next accumulator value; no backpressure, consumes one tap per cycle.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] tap,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [3:0]               shift,
  output logic [DATA_W-1:0]        result
);

  logic                     vld_q;
  logic                     first_q;
  logic signed [DATA_W-1:0] tap_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  px_ext;
  logic signed [ACC_W-1:0]  tap_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  shifted;

`ifdef CONV_RELU_EN
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((64'sd1 <<< DATA_W) - 64'sd1);
`else
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - 1;
`endif

  // Tap and first flag are delayed to line up with the 1-cycle read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      tap_q   <= '0;
      acc     <= '0;
    end else begin
      vld_q   <= rd_en;
      first_q <= rd_en & first;
      tap_q   <= tap;
      acc     <= acc_nxt;
    end
  end

  always_comb begin
    px_ext   = {{(ACC_W - DATA_W){1'b0}}, rdata};
    tap_ext  = {{(ACC_W - DATA_W){tap_q[DATA_W-1]}}, tap_q};
    prod     = px_ext * tap_ext;
    acc_base = first_q ? '0 : acc;
    acc_nxt  = vld_q ? acc_base + prod : acc;
    shifted  = acc_nxt >>> shift;
`ifdef CONV_RELU_EN
    if (shifted[ACC_W-1])    result = '0;
    else if (shifted > U_MAX) result = U_MAX[DATA_W-1:0];
    else                      result = shifted[DATA_W-1:0];
`else
    if (shifted > S_MAX)      result = S_MAX[DATA_W-1:0];
    else if (shifted < S_MIN) result = S_MIN[DATA_W-1:0];
    else                      result = shifted[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/conv_engine.sv
// Valid-mode KSIZE x KSIZE convolution over a RAM image; KSIZE*KSIZE+2 cycles per output pixel.
// No backpressure: memory must answer reads in 1 cycle. CONV_RELU_EN selects unsigned ReLU saturation.
module conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int KSIZE  = KSIZE_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       img_w,
  input  logic [ADDR_W-1:0]       img_h,
  input  logic [ADDR_W-1:0]       src_base,
  input  logic [ADDR_W-1:0]       dst_base,
  input  logic [3:0]              shift,
  input  logic                    k_wr_en,
  input  logic [idx_w(KSIZE)-1:0] k_wr_idx,
  input  logic [DATA_W-1:0]       k_wr_data,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int                KK     = KSIZE * KSIZE;
  localparam int                TW     = idx_w(KSIZE);
  localparam logic [TW-1:0]     T_LAST = TW'(KK - 1);
  localparam logic [TW-1:0]     J_LAST = TW'(KSIZE - 1);
  localparam logic [ADDR_W-1:0] K_A    = ADDR_W'(KSIZE);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  conv_state_t              state;
  logic signed [DATA_W-1:0] taps [KK];
  logic [TW-1:0]            t;
  logic [TW-1:0]            j;
  logic [ADDR_W-1:0]        ow_q;
  logic [ADDR_W-1:0]        oh_q;
  logic [ADDR_W-1:0]        r;
  logic [ADDR_W-1:0]        c;
  logic [ADDR_W-1:0]        origin;
  logic [ADDR_W-1:0]        dst_ptr;
  logic [3:0]               shift_q;
  logic [DATA_W-1:0]        mac_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < KK; n++) taps[n] <= '0;
    end else if (state == IDLE && k_wr_en && int'(k_wr_idx) < KK) begin
      taps[k_wr_idx] <= signed'(k_wr_data);
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en  (mem_rd_en),
    .first  (t == '0),
    .tap    (taps[t]),
    .rdata  (mem_rdata),
    .shift  (shift_q),
    .result (mac_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      t         <= '0;
      j         <= '0;
      ow_q      <= '0;
      oh_q      <= '0;
      r         <= '0;
      c         <= '0;
      origin    <= '0;
      dst_ptr   <= '0;
      shift_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (img_w < K_A || img_h < K_A) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= READ;
              err       <= 1'b0;
              mem_rd_en <= 1'b1;
              mem_addr  <= src_base;
              origin    <= src_base;
              dst_ptr   <= dst_base;
              ow_q      <= img_w - K_A + ONE_A;
              oh_q      <= img_h - K_A + ONE_A;
              shift_q   <= shift;
              r         <= '0;
              c         <= '0;
              t         <= '0;
              j         <= '0;
            end
          end
        end
        READ: begin
          if (t == T_LAST) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
            t         <= '0;
          end else if (j == J_LAST) begin
            // next kernel row starts img_w-KSIZE+1 past the current one's last tap
            t        <= t + 1'b1;
            j        <= '0;
            mem_addr <= mem_addr + ow_q;
          end else begin
            t        <= t + 1'b1;
            j        <= j + 1'b1;
            mem_addr <= mem_addr + ONE_A;
          end
        end
        DRAIN: begin
          state     <= WRITE;
          mem_wr_en <= 1'b1;
          mem_addr  <= dst_ptr;
          mem_wdata <= mac_result;
        end
        WRITE: begin
          mem_wr_en <= 1'b0;
          dst_ptr   <= dst_ptr + ONE_A;
          t         <= '0;
          j         <= '0;
          if (c == ow_q - ONE_A) begin
            c <= '0;
            if (r == oh_q - ONE_A) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              // last window of a row sits KSIZE before the next row's first window
              state     <= READ;
              r         <= r + ONE_A;
              origin    <= origin + K_A;
              mem_addr  <= origin + K_A;
              mem_rd_en <= 1'b1;
            end
          end else begin
            state     <= READ;
            c         <= c + ONE_A;
            origin    <= origin + ONE_A;
            mem_addr  <= origin + ONE_A;
            mem_rd_en <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: fixed scenario table, hand-written error/disturb/reset sequences, random images.
// Expected pixels come from a direct sum-of-products model over the bench's own memory image.
module tb_conv_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] img_w, img_h, src_base, dst_base;
  logic [3:0]  shift;
  logic        k_wr_en;
  logic [3:0]  k_wr_idx;
  logic [7:0]  k_wr_data;
  logic [11:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        busy, done, err;

  conv_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .shift     (shift),
    .k_wr_en   (k_wr_en),
    .k_wr_idx  (k_wr_idx),
    .k_wr_data (k_wr_data),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int w; int h; int src; int dst; int sh;
    int kmode; int pmode;
    int cycles; int first; int chk_first;
  } vec_t;

`ifdef CONV_RELU_EN
  localparam int SAT_HI = 255;
  localparam int NEG90  = 0;
`else
  localparam int SAT_HI = 127;
  localparam int NEG90  = 8'hA6;
`endif

  logic [7:0] mem [4096];
  wr_t        wq[$];
  int         rd_cnt = 0;
  int         both_cnt = 0;
  int         kern [9];
  int         n_chk = 0;
  int         n_fail = 0;

  // Reads return data one cycle later; writes are only logged, the source image is never disturbed
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (mem_wr_en) wq.push_back('{mem_addr, mem_wdata});
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
`ifdef CONV_RELU_EN
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
`else
    if (v > 127) return 127;
    if (v < -128) return 128;
    return v & 255;
`endif
  endfunction

  task automatic set_kernel(input int mode);
    for (int n = 0; n < 9; n++) begin
      case (mode)
        0:       kern[n] = (n == 4) ? 1 : 0;
        1:       kern[n] = 1;
        2:       kern[n] = -1;
        default: kern[n] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
  endtask

  task automatic load_kernel();
    for (int n = 0; n < 9; n++) begin
      k_wr_en   = 1'b1;
      k_wr_idx  = 4'(n);
      k_wr_data = 8'(kern[n]);
      @(posedge clk); #1;
    end
    k_wr_en = 1'b0;
  endtask

  task automatic fill(input int mode, input int src, input int n);
    for (int k = 0; k < n; k++) begin
      int a;
      a = (src + k) % 4096;
      case (mode)
        0:       mem[a] = 8'(a);
        1:       mem[a] = 8'd200;
        2:       mem[a] = 8'd10;
        default: mem[a] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic run_conv(input int w, input int h, input int src, input int dst, input int sh,
                          input bit disturb, output int cycles, output int e_at_done);
    img_w = 12'(w); img_h = 12'(h); src_base = 12'(src); dst_base = 12'(dst); shift = 4'(sh);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 3000) begin
      if (disturb && cycles >= 5 && cycles < 15) begin
        start = 1'b1; k_wr_en = 1'b1; k_wr_idx = 4'd4; k_wr_data = 8'h00; img_w = 12'd2;
      end else begin
        start = 1'b0; k_wr_en = 1'b0; img_w = 12'(w);
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0; k_wr_en = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    e_at_done = int'(err);
    @(posedge clk); #1;
  endtask

  task automatic check_out(input int w, input int h, input int src, input int dst, input int sh,
                           input int wr_base);
    int ow, oh, idx;
    ow  = w - 2;
    oh  = h - 2;
    idx = wr_base;
    chk("wr_count", wq.size() - wr_base, ow * oh);
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        int acc;
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += int'(mem[(src + (r + i) * w + c + j) % 4096]) * kern[i * 3 + j];
        if (idx < wq.size()) begin
          chk("wr_addr", int'(wq[idx].addr), (dst + r * ow + c) % 4096);
          chk("wr_data", int'(wq[idx].data), sat(acc >>> sh));
        end
        idx++;
      end
    end
  endtask

  initial begin
    vec_t vt [6];
    int   cyc, e, wb, rb;

    vt[0] = '{4, 4, 0,    2048, 0, 0, 0, 45, 5,      1};
    vt[1] = '{4, 4, 0,    2048, 0, 1, 1, 45, SAT_HI, 1};
    vt[2] = '{4, 4, 16,   2100, 0, 2, 2, 45, NEG90,  1};
    vt[3] = '{3, 3, 300,  2200, 0, 1, 0, 12, SAT_HI, 1};
    vt[4] = '{5, 4, 4090, 2300, 2, 3, 3, 67, 0,      0};
    vt[5] = '{6, 3, 100,  4093, 1, 3, 3, 45, 0,      0};

    rst_n = 1'b0; start = 1'b0; k_wr_en = 1'b0; k_wr_idx = '0; k_wr_data = '0;
    img_w = '0; img_h = '0; src_base = '0; dst_base = '0; shift = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      set_kernel(vt[v].kmode);
      load_kernel();
      fill(vt[v].pmode, vt[v].src, vt[v].w * vt[v].h);
      wb = wq.size(); rb = rd_cnt;
      run_conv(vt[v].w, vt[v].h, vt[v].src, vt[v].dst, vt[v].sh, 1'b0, cyc, e);
      chk("vec_cycles", cyc, vt[v].cycles);
      chk("vec_err", e, 0);
      chk("vec_idle", busy, 0);
      chk("vec_reads", rd_cnt - rb, (vt[v].w - 2) * (vt[v].h - 2) * 9);
      check_out(vt[v].w, vt[v].h, vt[v].src, vt[v].dst, vt[v].sh, wb);
      if (vt[v].chk_first != 0 && wq.size() > wb) chk("vec_first_px", int'(wq[wb].data), vt[v].first);
    end

    // Too-narrow and too-short images: immediate done with err, no memory traffic
    wb = wq.size(); rb = rd_cnt;
    run_conv(2, 4, 0, 2048, 0, 1'b0, cyc, e);
    chk("errw_cycles", cyc, 1);
    chk("errw_flag", e, 1);
    chk("errw_reads", rd_cnt - rb, 0);
    chk("errw_writes", wq.size() - wb, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_hold", err, 1);
    chk("err_done_low", done, 0);
    chk("err_busy_low", busy, 0);
    run_conv(5, 2, 0, 2048, 0, 1'b0, cyc, e);
    chk("errh_flag", e, 1);
    chk("errh_reads", rd_cnt - rb, 0);

    // start, kernel writes and config changes mid-run must all be ignored
    set_kernel(0);
    load_kernel();
    fill(0, 0, 16);
    wb = wq.size();
    run_conv(4, 4, 0, 2048, 0, 1'b1, cyc, e);
    chk("dist_cycles", cyc, 45);
    chk("dist_err_cleared", e, 0);
    check_out(4, 4, 0, 2048, 0, wb);

    // Reset during the second pixel's READ
    wb = wq.size();
    img_w = 12'd4; img_h = 12'd4; src_base = 12'd0; dst_base = 12'd2048; shift = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("abort_in_read", mem_rd_en, 1);
    chk("abort_wr_before", wq.size() - wb, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_wr_en", mem_wr_en, 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_wdata", int'(mem_wdata), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_more_wr", wq.size() - wb, 1);
    chk("abort_stays_idle", busy, 0);
    for (int n = 0; n < 9; n++) kern[n] = 0;
    wb = wq.size();
    run_conv(4, 4, 0, 2048, 0, 1'b0, cyc, e);
    check_out(4, 4, 0, 2048, 0, wb);
    set_kernel(0);
    load_kernel();
    wb = wq.size();
    run_conv(4, 4, 0, 2048, 0, 1'b0, cyc, e);
    chk("restart_cycles", cyc, 45);
    check_out(4, 4, 0, 2048, 0, wb);

    for (int it = 0; it < 8; it++) begin
      int w, h, src, dst, sh;
      w   = int'($urandom_range(3, 8));
      h   = int'($urandom_range(3, 6));
      src = int'($urandom_range(0, 4095));
      dst = (src + 2048) % 4096;
      sh  = int'($urandom_range(0, 15));
      set_kernel(3);
      load_kernel();
      fill(3, src, w * h);
      wb = wq.size();
      run_conv(w, h, src, dst, sh, 1'b0, cyc, e);
      chk("rand_cycles", cyc, (w - 2) * (h - 2) * 11 + 1);
      check_out(w, h, src, dst, sh, wb);
    end

    chk("rd_wr_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
